eink_spi_byte_tx: RTL

// - SPI transmit stage directly downstream of the e-ink display sequencer.
// - Accepts one byte per write handshake and shifts it MSB-first, SPI mode 0, to the SSD1680.
// - Owns the chip select framing: CSB stays low across streamed bytes and releases with hold/guard timing.
// - Drives D/C, latched per byte, so command/data framing is glitch-free at the panel.

---
 rtl/eink_spi_byte_tx.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/eink_spi_byte_tx.sv
// eink_spi_byte_tx: SPI mode-0 byte transmitter for the SSD1680 e-ink panel.
// It sends one byte MSB-first for each write handshake and owns the CSB framing.
// CSB stays low across streamed bytes. When the frame closes, CSB is held low
// for one half-period and then released with a guard time. D/C is latched per byte.
// Optional build macro EINK_SPI_RX_EN adds MISO capture and the o_rx_data port.
module eink_spi_byte_tx #(
    parameter int DIV_W      = 8,
    parameter int GUARD_MULT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_prescaler,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    input  logic             i_wr_dc,
    input  logic             i_stream,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_spi_csb,
    output logic             o_spi_sck,
    output logic             o_spi_mosi,
    output logic             o_spi_mosi_oe,
    output logic             o_spi_dc,
    input  logic             i_spi_miso
`ifdef EINK_SPI_RX_EN
    ,
    output logic [7:0]       o_rx_data
`endif
);

    // Guard repeats are counted in whole half-periods so the half-period counter stays DIV_W bits.
    localparam int GW       = (GUARD_MULT > 1) ? $clog2(GUARD_MULT) : 1;
    localparam bit GUARD_EN = (GUARD_MULT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [DIV_W-1:0] r_cnt,   w_cnt_next;
    logic [DIV_W-1:0] r_h,     w_h_next;
    logic [2:0]       r_bit,   w_bit_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [GW-1:0]    r_grep,  w_grep_next;
    logic             r_busy,  w_busy_next;
    logic             r_done,  w_done_next;
    logic             r_csb,   w_csb_next;
    logic             r_sck,   w_sck_next;
    logic             r_mosi,  w_mosi_next;
    logic             r_oe,    w_oe_next;
    logic             r_dc,    w_dc_next;

    logic [DIV_W-1:0] w_h_in;
    logic             w_cnt_zero;

`ifdef EINK_SPI_RX_EN
    logic [7:0]       r_rx_shift, w_rx_shift_next;
    logic [7:0]       r_rx_data,  w_rx_data_next;
`else
    logic             w_unused_miso;
    assign w_unused_miso = i_spi_miso;
`endif

    // Prescaler of zero is treated as a half-period of one clock.
    assign w_h_in     = (i_prescaler == {DIV_W{1'b0}}) ? DIV_W'(1) : i_prescaler;
    assign w_cnt_zero = (r_cnt == {DIV_W{1'b0}});

    // Compute the next state and the next value of every output and datapath register.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_h_next     = r_h;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_grep_next  = r_grep;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_csb_next   = r_csb;
        w_sck_next   = r_sck;
        w_mosi_next  = r_mosi;
        w_dc_next    = r_dc;
`ifdef EINK_SPI_RX_EN
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_wr_en) begin
                    // A write wins over a simultaneous stream drop. The frame closes after this byte.
                    w_state_next = ST_SHIFT;
                    w_h_next     = w_h_in;
                    w_cnt_next   = w_h_in - DIV_W'(1);
                    w_shift_next = i_wr_data;
                    w_mosi_next  = i_wr_data[7];
                    w_bit_next   = 3'd0;
                    w_busy_next  = 1'b1;
                    w_csb_next   = 1'b0;
                    w_sck_next   = 1'b0;
                    w_dc_next    = i_wr_dc;
                end else if (!r_csb && !i_stream) begin
                    // The frame was left open and the stream has now ended, so close it.
                    w_state_next = ST_HOLD;
                    w_cnt_next   = r_h - DIV_W'(1);
                    w_busy_next  = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_cnt_zero) begin
                    w_cnt_next = r_h - DIV_W'(1);
                    if (!r_sck) begin
                        // Rising edge: the panel samples MOSI here.
                        w_sck_next = 1'b1;
`ifdef EINK_SPI_RX_EN
                        w_rx_shift_next = {r_rx_shift[6:0], i_spi_miso};
`endif
                    end else begin
                        // Falling edge: advance MOSI, or finish the byte after the eighth bit.
                        w_sck_next = 1'b0;
                        if (r_bit == 3'd7) begin
`ifdef EINK_SPI_RX_EN
                            w_rx_data_next = r_rx_shift;
`endif
                            if (i_stream) begin
                                w_state_next = ST_IDLE;
                                w_busy_next  = 1'b0;
                                w_done_next  = 1'b1;
                            end else begin
                                w_state_next = ST_HOLD;
                            end
                        end else begin
                            w_bit_next   = r_bit + 3'd1;
                            w_shift_next = {r_shift[6:0], 1'b0};
                            w_mosi_next  = r_shift[6];
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_csb_next = 1'b1;
                    if (GUARD_EN) begin
                        w_state_next = ST_GUARD;
                        w_cnt_next   = r_h - DIV_W'(1);
                        w_grep_next  = GW'(GUARD_MULT - 1);
                    end else begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end
            end
            ST_GUARD: begin
                if (w_cnt_zero) begin
                    if (r_grep == {GW{1'b0}}) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_grep_next = r_grep - GW'(1);
                        w_cnt_next  = r_h - DIV_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt - DIV_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
                w_csb_next   = 1'b1;
                w_sck_next   = 1'b0;
            end
        endcase
        w_oe_next = ~w_csb_next;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered pad outputs; reset aborts any byte in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= {DIV_W{1'b0}};
            r_h     <= DIV_W'(1);
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_grep  <= {GW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_csb   <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_oe    <= 1'b0;
            r_dc    <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_next;
            r_h     <= w_h_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_grep  <= w_grep_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_csb   <= w_csb_next;
            r_sck   <= w_sck_next;
            r_mosi  <= w_mosi_next;
            r_oe    <= w_oe_next;
            r_dc    <= w_dc_next;
        end
    end

`ifdef EINK_SPI_RX_EN
    // MISO capture shift register and the byte presented at done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_shift <= 8'h00;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
        end
    end

    assign o_rx_data = r_rx_data;
`endif

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_spi_csb     = r_csb;
    assign o_spi_sck     = r_sck;
    assign o_spi_mosi    = r_mosi;
    assign o_spi_mosi_oe = r_oe;
    assign o_spi_dc      = r_dc;

endmodule
